irq_controller: RTL and testbench
=================================

# irq_controller

Parametrised multi-source interrupt controller: successor to the single-strobe controller in the RISC-V core. Arbitrates up to 32 masked interrupt sources with fixed-priority or round-robin selection, issues a one-cycle interrupt strobe with the winning source ID to the CSR/trap unit, and holds off further requests until the handler signals completion. Sits between peripheral interrupt lines and the core's trap logic (mcause/mie path).

## Interface
- N_SRC, 32: number of interrupt sources, legal range 1..32.
- ID_W, 5: width of the source ID; must satisfy 2^ID_W >= N_SRC.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.

- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- int_req_i  in  N_SRC  raw interrupt request lines from devices.
- int_mie_i  in  N_SRC  per-source enable mask; 1 = enabled.
- int_rst_i  in  1  handler done (mret) pulse from the core.
- int_int_o  out  1  interrupt strobe, exactly one cycle per grant.
- int_mcause_o  out  ID_W  ID of the source being or last serviced.
- int_busy_o  out  1  1 while a grant is outstanding.
- int_pending_o  out  N_SRC  current pending vector, before masking.

## Operation
- Eligible vector = pending & int_mie_i. In level mode, pending = int_req_i. In edge mode, pending = latched register (see Configuration).
- FSM states:
  - IDLE: int_busy_o=0. If eligible != 0, latch the winner ID into the mcause register and go to STROBE.
  - STROBE: int_int_o=1, int_busy_o=1. If int_rst_i=1, go to IDLE; otherwise go to WAIT.
  - WAIT: int_busy_o=1. Stay until int_rst_i=1, then go to IDLE.
- int_rst_i is ignored in IDLE.
- Fixed priority: the winner is the lowest set index of the eligible vector.
- Round-robin:
  - Pointer `last` holds the ID of the last grant.
  - The search starts at last+1 and wraps modulo N_SRC; the pointer updates only on a grant.
  - Reset value of `last` is N_SRC-1, so the first search starts at 0.
  - With N_SRC=1 the pointer is constant 0.
- Changes to the mask or request lines during STROBE/WAIT do not alter int_mcause_o or the FSM.
- int_mcause_o is zero-extended from the internal index; it holds its value until the next grant.
- Reset values (asserted asynchronously, mid-operation included):
  - FSM = IDLE, int_int_o=0, int_busy_o=0, int_mcause_o=0.
  - Pending register = 0, request-history register = 0, RR pointer = N_SRC-1.
  - int_pending_o = 0 in edge mode; it equals int_req_i in level mode.

## Timing
- Grant latency: eligible source present at rising edge k (in IDLE) -> int_int_o=1 and valid int_mcause_o during cycle k..k+1 (one edge).
- int_int_o is a registered state decode: glitch-free, never wider than one cycle.
- Completion: int_rst_i sampled at edge m (in STROBE/WAIT) -> IDLE after edge m.
  - The earliest next strobe follows edge m+1.
  - This gives a minimum of one IDLE cycle between consecutive strobes.
- Edge mode: a request edge between samples k-1 and k sets pending at edge k; it is eligible for arbitration at edge k+1.

## Configuration
- Macro IRQ_CTRL_EDGE_EN.
- Defined: edge-triggered sources.
  - Register req_q <= int_req_i.
  - pending[i] is set on int_req_i[i] & ~req_q[i], regardless of mask.
  - pending[served] is cleared at the edge where int_rst_i is accepted.
  - A new rising edge on the served source in that same cycle wins: the bit stays set.
  - A source held high through reset release counts as one edge.
- Undefined: level-sensitive.
  - No pending or req_q flops; pending = int_req_i.
  - A source still asserted after int_rst_i is re-granted after the one IDLE cycle.

## Test plan
- Fixed priority, level mode: mie=0xFFFFFFFF, req=0x00000014 in IDLE -> one-cycle int_int_o with mcause=2, busy high until int_rst_i; after that, mcause=2 again if req is unchanged, or 4 if bit 2 is dropped.
- Round-robin: ARB_MODE=1, req=0x0000000B held, int_rst_i 2 cycles after each strobe -> mcause sequence 0,1,3,0,1; exactly one IDLE cycle between strobes.
- Masking: req=0x00000100, mie=0 -> no strobe for 20 cycles; set mie[8] -> strobe with mcause=8 one edge later; clear mie[8] in WAIT -> busy stays 1 until int_rst_i.
- Edge mode (IRQ_CTRL_EDGE_EN):
  - A 1-cycle pulse on req[5] while masked -> int_pending_o=0x20.
  - Unmasking -> strobe with mcause=5.
  - int_rst_i coinciding with a new req[5] rising edge -> int_pending_o stays 0x20 and a second strobe follows.
- Async reset mid-WAIT: drop reset between edges -> int_busy_o, int_int_o, int_mcause_o go to 0 immediately and int_pending_o clears (edge mode).
  - After release with req=0x1 -> strobe with mcause=0 on the second edge.
- N_SRC=3, ID_W=2, ARB_MODE=1, req=0x7 -> mcause sequence 0,1,2,0 (wrap-around), with the upper bits of int_mcause_o correctly zero.

Source files
------------

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - multi-source interrupt controller with fixed-priority or round-robin arbitration
// Optional feature macro: IRQ_CTRL_EDGE_EN (edge-triggered sources); default build is level-sensitive.
module irq_controller #(
  parameter int N_SRC    = 32,
  parameter int ID_W     = 5,
  parameter int ARB_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] int_mie_i,
  input  logic             int_rst_i,
  output logic             int_int_o,
  output logic [ID_W-1:0]  int_mcause_o,
  output logic             int_busy_o,
  output logic [N_SRC-1:0] int_pending_o
);

  // Index width used to address one source; kept at least one bit for N_SRC=1.
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT
  } state_t;

  state_t           r_state;
  logic             r_int;
  logic             r_busy;
  logic [ID_W-1:0]  r_mcause;
  logic [ID_W-1:0]  r_last;

  logic [N_SRC-1:0] w_pending;
  logic [N_SRC-1:0] w_eligible;
  logic [ID_W-1:0]  w_win_id;
  logic             w_win_valid;
  logic             w_accept;

  // Completion is only meaningful while a grant is outstanding.
  assign w_accept = (r_state != S_IDLE) && int_rst_i;

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_SRC-1:0] r_req_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;

  // req_q resets to 0, so a line held high through reset release reads as one edge.
  assign w_rise = int_req_i & ~r_req_q;

  // Clear mask for the source being serviced, active only on the accepted completion.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_clr[i] = w_accept && (r_mcause == ID_W'(i));
    end
  end

  // Edge latch: a fresh edge overrides a same-cycle clear so it is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= int_req_i;
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  assign w_pending = r_pending;
`else
  assign w_pending = int_req_i;
`endif

  assign w_eligible = w_pending & int_mie_i;

  // Winner select; loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    if (ARB_MODE == 0) begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (w_eligible[i]) begin
          w_win_valid = 1'b1;
          w_win_id    = ID_W'(i);
        end
      end
    end else begin
      for (int off = N_SRC; off >= 1; off--) begin
        if (w_eligible[IDX_W'((int'(r_last) + off) % N_SRC)]) begin
          w_win_valid = 1'b1;
          w_win_id    = ID_W'((int'(r_last) + off) % N_SRC);
        end
      end
    end
  end

  // Grant FSM with registered strobe/busy so the strobe is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_int    <= 1'b0;
      r_busy   <= 1'b0;
      r_mcause <= '0;
      r_last   <= ID_W'(N_SRC - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          r_int <= 1'b0;
          if (w_win_valid) begin
            r_state  <= S_STROBE;
            r_int    <= 1'b1;
            r_busy   <= 1'b1;
            r_mcause <= w_win_id;
            r_last   <= w_win_id;
          end
        end
        S_STROBE: begin
          r_int <= 1'b0;
          if (int_rst_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_int <= 1'b0;
          if (int_rst_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_int   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign int_int_o     = r_int;
  assign int_busy_o    = r_busy;
  assign int_mcause_o  = r_mcause;
  assign int_pending_o = w_pending;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller (fixed, round-robin, 3-source, reset)
module tb_irq_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [31:0] a_req, a_mie, a_pend;
  logic        a_rst, a_int, a_busy;
  logic [4:0]  a_mc;

  logic [31:0] b_req, b_mie, b_pend;
  logic        b_rst, b_int, b_busy;
  logic [4:0]  b_mc;

  logic [2:0]  c_req, c_mie, c_pend;
  logic        c_rst, c_int, c_busy;
  logic [1:0]  c_mc;

  int tests = 0;
  int fails = 0;
  int q_a[$];
  int q_b[$];
  int q_c[$];
  logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0;

  irq_controller #(.N_SRC(32), .ID_W(5), .ARB_MODE(0)) dut_a (
    .clk(clk), .reset(rst_n), .int_req_i(a_req), .int_mie_i(a_mie), .int_rst_i(a_rst),
    .int_int_o(a_int), .int_mcause_o(a_mc), .int_busy_o(a_busy), .int_pending_o(a_pend));

  irq_controller #(.N_SRC(32), .ID_W(5), .ARB_MODE(1)) dut_b (
    .clk(clk), .reset(rst_n), .int_req_i(b_req), .int_mie_i(b_mie), .int_rst_i(b_rst),
    .int_int_o(b_int), .int_mcause_o(b_mc), .int_busy_o(b_busy), .int_pending_o(b_pend));

  irq_controller #(.N_SRC(3), .ID_W(2), .ARB_MODE(1)) dut_c (
    .clk(clk), .reset(rst_n), .int_req_i(c_req), .int_mie_i(c_mie), .int_rst_i(c_rst),
    .int_int_o(c_int), .int_mcause_o(c_mc), .int_busy_o(c_busy), .int_pending_o(c_pend));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe monitors: every strobe pops one expected ID and must be a single cycle wide.
  always @(negedge clk) begin
    if (a_int) begin
      check("a_strobe_width", {31'b0, a_prev}, 32'd0);
      check("a_strobe_expected", {31'b0, q_a.size() > 0}, 32'd1);
      if (q_a.size() > 0) check("a_mcause", {27'b0, a_mc}, q_a.pop_front());
    end
    a_prev = a_int;
  end

  always @(negedge clk) begin
    if (b_int) begin
      check("b_strobe_width", {31'b0, b_prev}, 32'd0);
      check("b_strobe_expected", {31'b0, q_b.size() > 0}, 32'd1);
      if (q_b.size() > 0) check("b_mcause", {27'b0, b_mc}, q_b.pop_front());
    end
    b_prev = b_int;
  end

  always @(negedge clk) begin
    if (c_int) begin
      check("c_strobe_width", {31'b0, c_prev}, 32'd0);
      check("c_strobe_expected", {31'b0, q_c.size() > 0}, 32'd1);
      if (q_c.size() > 0) check("c_mcause", {30'b0, c_mc}, q_c.pop_front());
    end
    c_prev = c_int;
  end

  initial begin
    rst_n = 1'b0;
    a_req = '0; a_mie = '0; a_rst = 1'b0;
    b_req = '0; b_mie = '0; b_rst = 1'b0;
    c_req = '0; c_mie = '0; c_rst = 1'b0;
    cyc(2);
    check("rst_int", {31'b0, a_int}, 32'd0);
    check("rst_busy", {31'b0, a_busy}, 32'd0);
    check("rst_mcause", {27'b0, a_mc}, 32'd0);
    check("rst_pending", a_pend, 32'd0);
    check("rst_b_mcause", {27'b0, b_mc}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

`ifndef IRQ_CTRL_EDGE_EN
    // Fixed priority, level mode
    a_mie = 32'hFFFF_FFFF; a_req = 32'h14; q_a.push_back(2);
    cyc(1);
    check("fp_strobe", {31'b0, a_int}, 32'd1);
    check("fp_busy", {31'b0, a_busy}, 32'd1);
    check("fp_mcause", {27'b0, a_mc}, 32'd2);
    check("fp_pending", a_pend, 32'h14);
    cyc(1);
    check("fp_strobe_off", {31'b0, a_int}, 32'd0);
    check("fp_busy_wait", {31'b0, a_busy}, 32'd1);
    cyc(3);
    check("fp_busy_hold", {31'b0, a_busy}, 32'd1);
    q_a.push_back(2); a_rst = 1'b1;
    cyc(1); a_rst = 1'b0;
    check("fp_idle_busy", {31'b0, a_busy}, 32'd0);
    check("fp_idle_int", {31'b0, a_int}, 32'd0);
    check("fp_mcause_hold", {27'b0, a_mc}, 32'd2);
    cyc(1);
    check("fp_regrant", {31'b0, a_int}, 32'd1);
    a_req = 32'h10; q_a.push_back(4); a_rst = 1'b1;
    cyc(1); a_rst = 1'b0;
    check("fp_rst_in_strobe", {31'b0, a_busy}, 32'd0);
    cyc(1);
    check("fp_next", {31'b0, a_int}, 32'd1);
    check("fp_next_mcause", {27'b0, a_mc}, 32'd4);
    a_req = '0; a_rst = 1'b1;
    cyc(1); a_rst = 1'b0;
    cyc(3);
    check("fp_quiet", {31'b0, a_busy}, 32'd0);

    // Masking
    a_mie = '0; a_req = 32'h100;
    cyc(20);
    check("mask_no_grant", {31'b0, a_busy}, 32'd0);
    check("mask_pending", a_pend, 32'h100);
    a_mie = 32'h100; q_a.push_back(8);
    cyc(1);
    check("mask_strobe", {31'b0, a_int}, 32'd1);
    check("mask_mcause", {27'b0, a_mc}, 32'd8);
    cyc(1); a_mie = '0;
    cyc(3);
    check("mask_busy_hold", {31'b0, a_busy}, 32'd1);
    a_rst = 1'b1;
    cyc(1); a_rst = 1'b0;
    check("mask_done", {31'b0, a_busy}, 32'd0);
    cyc(3);
    check("mask_no_regrant", {31'b0, a_busy}, 32'd0);
    a_req = '0; a_mie = 32'hFFFF_FFFF;

    // Round-robin, 32 sources
    b_mie = 32'hFFFF_FFFF; b_req = 32'h0B;
    q_b.push_back(0); q_b.push_back(1); q_b.push_back(3); q_b.push_back(0); q_b.push_back(1);
    cyc(1);
    check("rr_first", {31'b0, b_int}, 32'd1);
    check("rr_pending", b_pend, 32'h0B);
    for (int k = 0; k < 5; k++) begin
      cyc(2);
      b_rst = 1'b1;
      if (k == 4) b_req = '0;
      cyc(1); b_rst = 1'b0;
      check("rr_idle_gap", {31'b0, b_busy}, 32'd0);
      cyc(1);
      check("rr_next_strobe", {31'b0, b_int}, (k < 4) ? 32'd1 : 32'd0);
    end

    // Round-robin, 3 sources, wrap-around
    c_mie = 3'b111; c_req = 3'b111;
    q_c.push_back(0); q_c.push_back(1); q_c.push_back(2); q_c.push_back(0);
    cyc(1);
    check("n3_first", {31'b0, c_int}, 32'd1);
    check("n3_pending", {29'b0, c_pend}, 32'd7);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      c_rst = 1'b1;
      if (k == 3) c_req = '0;
      cyc(1); c_rst = 1'b0;
      check("n3_idle_gap", {31'b0, c_busy}, 32'd0);
      cyc(1);
      check("n3_next_strobe", {31'b0, c_int}, (k < 3) ? 32'd1 : 32'd0);
    end
`else
    // Edge mode: masked pulse latches, unmask grants, coincident edge survives the clear
    a_mie = '0; a_req = 32'h20;
    cyc(1); a_req = '0;
    check("e_pend_pulse", a_pend, 32'h20);
    cyc(2);
    check("e_pend_hold", a_pend, 32'h20);
    check("e_masked_idle", {31'b0, a_busy}, 32'd0);
    a_mie = 32'h20; q_a.push_back(5);
    cyc(1);
    check("e_strobe", {31'b0, a_int}, 32'd1);
    check("e_mcause", {27'b0, a_mc}, 32'd5);
    cyc(1);
    a_rst = 1'b1; a_req = 32'h20; q_a.push_back(5);
    cyc(1); a_rst = 1'b0; a_req = '0;
    check("e_pend_kept", a_pend, 32'h20);
    check("e_idle", {31'b0, a_busy}, 32'd0);
    cyc(1);
    check("e_second_strobe", {31'b0, a_int}, 32'd1);
    a_rst = 1'b1;
    cyc(1); a_rst = 1'b0;
    check("e_pend_clr", a_pend, 32'd0);
    cyc(2);
    check("e_quiet", {31'b0, a_busy}, 32'd0);
`endif

    // Asynchronous reset in the middle of WAIT
    a_mie = 32'hFFFF_FFFF; a_req = 32'h8; q_a.push_back(3);
`ifdef IRQ_CTRL_EDGE_EN
    cyc(2);
`else
    cyc(1);
`endif
    check("ar_strobe", {31'b0, a_int}, 32'd1);
    check("ar_mcause", {27'b0, a_mc}, 32'd3);
    cyc(1);
    check("ar_wait", {31'b0, a_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", {31'b0, a_busy}, 32'd0);
    check("ar_int", {31'b0, a_int}, 32'd0);
    check("ar_mcause_clr", {27'b0, a_mc}, 32'd0);
`ifdef IRQ_CTRL_EDGE_EN
    check("ar_pending", a_pend, 32'd0);
`else
    check("ar_pending", a_pend, 32'h8);
`endif
    a_req = 32'h1; q_a.push_back(0);
    rst_n = 1'b1;
`ifdef IRQ_CTRL_EDGE_EN
    cyc(1);
    check("ar_first_edge", {31'b0, a_int}, 32'd0);
`endif
    cyc(1);
    check("ar_regrant", {31'b0, a_int}, 32'd1);
    check("ar_regrant_mcause", {27'b0, a_mc}, 32'd0);
    a_req = '0; a_rst = 1'b1;
    cyc(1); a_rst = 1'b0;
    cyc(3);

    check("a_queue_empty", q_a.size(), 32'd0);
    check("b_queue_empty", q_b.size(), 32'd0);
    check("c_queue_empty", q_c.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
